// File: rtl/capture_ctrl.sv
// Logic-probe acquisition: circular BRAM capture with guaranteed pre-trigger window, masked level/edge trigger, dump handoff.
// Latency: BRAM write one cycle after sample_en; start_dump pulses the cycle after the last post-trigger sample. No backpressure: samples outside capture states are dropped.
module capture_ctrl #(
    parameter int AW   = 10,
    parameter int PRE  = 32,
    parameter int POST = 96
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_en,
    input  logic [7:0]    sample_in,
    input  logic          arm,
    input  logic          abort,
    input  logic [7:0]    trig_mask,
    input  logic [7:0]    trig_val,
    input  logic          trig_edge,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [7:0]    wdata,
    output logic          start_dump,
    output logic [AW-1:0] start_addr,
    output logic [15:0]   count,
    input  logic          dump_busy,
    output logic          armed,
    output logic          triggered
);

    localparam logic [AW-1:0] PRE_A  = AW'(PRE);
    localparam logic [15:0]   PRE_C  = 16'(PRE);
    localparam logic [15:0]   POST_C = 16'(POST);
    localparam logic [15:0]   TOTAL  = 16'(PRE + POST);

    typedef enum logic [2:0] {
        S_IDLE, S_PREFILL, S_ARMED, S_POST, S_HANDOFF, S_WAIT_DUMP
    } state_t;

    state_t        state;
    logic [AW-1:0] wp;
    logic [AW-1:0] trig_addr;
    logic [15:0]   pre_cnt;
    logic [15:0]   post_cnt;
    logic          prev_match;
    logic          seen_busy;

    logic match;
    logic capturing;
    logic fire;

    assign match     = ((sample_in ^ trig_val) & trig_mask) == 8'h00;
    assign capturing = sample_en &&
                       (state == S_PREFILL || state == S_ARMED || state == S_POST);
    assign fire      = match && (!trig_edge || !prev_match);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= 8'h00;
            start_dump <= 1'b0;
            start_addr <= '0;
            count      <= TOTAL;
            armed      <= 1'b0;
            triggered  <= 1'b0;
            wp         <= '0;
            trig_addr  <= '0;
            pre_cnt    <= 16'd0;
            post_cnt   <= 16'd0;
            prev_match <= 1'b1;
            seen_busy  <= 1'b0;
        end else begin
            we         <= 1'b0;
            start_dump <= 1'b0;
            // The write belongs to the current state, even on an abort or transition cycle.
            if (capturing) begin
                we    <= 1'b1;
                waddr <= wp;
                wdata <= sample_in;
                wp    <= wp + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (arm && !abort) begin
                        pre_cnt    <= 16'd0;
                        post_cnt   <= 16'd0;
                        prev_match <= 1'b1;
                        armed      <= 1'b1;
                        state      <= (PRE == 0) ? S_ARMED : S_PREFILL;
                    end
                end
                S_PREFILL: begin
                    if (abort) begin
                        state <= S_IDLE;
                        armed <= 1'b0;
                    end else if (sample_en) begin
                        prev_match <= match;
                        pre_cnt    <= pre_cnt + 16'd1;
                        if (pre_cnt + 16'd1 == PRE_C) state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (abort) begin
                        state <= S_IDLE;
                        armed <= 1'b0;
                    end else if (sample_en) begin
                        prev_match <= match;
                        if (fire) begin
                            trig_addr <= wp;
                            triggered <= 1'b1;
                            armed     <= 1'b0;
                            post_cnt  <= 16'd1;
                            if (POST == 1) begin
                                state      <= S_HANDOFF;
                                start_dump <= 1'b1;
                                start_addr <= wp - PRE_A;
                                count      <= TOTAL;
                            end else begin
                                state <= S_POST;
                            end
                        end
                    end
                end
                S_POST: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        triggered <= 1'b0;
                    end else if (sample_en) begin
                        post_cnt <= post_cnt + 16'd1;
                        if (post_cnt + 16'd1 == POST_C) begin
                            state      <= S_HANDOFF;
                            start_dump <= 1'b1;
                            start_addr <= trig_addr - PRE_A;
                            count      <= TOTAL;
                        end
                    end
                end
                S_HANDOFF: begin
                    // start_dump is already high during this cycle, so an abort here cannot retract it.
                    seen_busy <= 1'b0;
                    if (abort) begin
                        state     <= S_IDLE;
                        triggered <= 1'b0;
                    end else begin
                        state <= S_WAIT_DUMP;
                    end
                end
                S_WAIT_DUMP: begin
                    if (dump_busy) begin
                        seen_busy <= 1'b1;
                    end else if (seen_busy) begin
                        state     <= S_IDLE;
                        triggered <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Randomized bench for capture_ctrl: a transaction-level model predicts BRAM writes and the dump handoff, a monitor scores them.
module tb_capture_ctrl;
    localparam int AW    = 4;
    localparam int PRE   = 4;
    localparam int POST  = 4;
    localparam int DEPTH = 1 << AW;
    localparam int NS    = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_en;
    logic [7:0]    sample_in;
    logic          arm;
    logic          abort;
    logic [7:0]    trig_mask;
    logic [7:0]    trig_val;
    logic          trig_edge;
    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic          start_dump;
    logic [AW-1:0] start_addr;
    logic [15:0]   count;
    logic          dump_busy;
    logic          armed;
    logic          triggered;

    always #5 clk = ~clk;

    capture_ctrl #(.AW(AW), .PRE(PRE), .POST(POST)) dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .sample_in(sample_in),
        .arm(arm), .abort(abort), .trig_mask(trig_mask), .trig_val(trig_val),
        .trig_edge(trig_edge), .we(we), .waddr(waddr), .wdata(wdata),
        .start_dump(start_dump), .start_addr(start_addr), .count(count),
        .dump_busy(dump_busy), .armed(armed), .triggered(triggered)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t           wq[$];
    logic [AW-1:0] dq[$];
    int            checks = 0;
    int            errors = 0;
    int            exp_wp = 0;
    logic [7:0]    smp[NS];
    wr_t           mon_w;
    logic [AW-1:0] mon_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every write and every dump handoff must match the next prediction.
    always @(negedge clk) begin
        if (rst) begin
            if (we) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write actual=%0h:%0h required=none", waddr, wdata);
                end else begin
                    mon_w = wq.pop_front();
                    chk("waddr", 32'(waddr), 32'(mon_w.addr));
                    chk("wdata", 32'(wdata), 32'(mon_w.data));
                end
            end
            if (start_dump) begin
                if (dq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_start_dump actual=%0h required=none", start_addr);
                end else begin
                    mon_a = dq.pop_front();
                    chk("start_addr", 32'(start_addr), 32'(mon_a));
                    chk("count", 32'(count), PRE + POST);
                end
            end
        end
    end

    function automatic bit is_match(input logic [7:0] s, input logic [7:0] m, input logic [7:0] v);
        return ((s ^ v) & m) == 8'h00;
    endfunction

    // First sample index at or after the pre-trigger window that satisfies the trigger rule.
    function automatic int find_trig(input logic [7:0] m, input logic [7:0] v, input bit ed);
        bit pm;
        for (int i = PRE; i < NS; i++) begin
            pm = (i == 0) ? 1'b1 : is_match(smp[i-1], m, v);
            if (is_match(smp[i], m, v) && (!ed || !pm)) return i;
        end
        return -1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"}, 32'(we), 0);
        chk({tag, "_waddr"}, 32'(waddr), 0);
        chk({tag, "_wdata"}, 32'(wdata), 0);
        chk({tag, "_start_dump"}, 32'(start_dump), 0);
        chk({tag, "_start_addr"}, 32'(start_addr), 0);
        chk({tag, "_count"}, 32'(count), PRE + POST);
        chk({tag, "_armed"}, 32'(armed), 0);
        chk({tag, "_triggered"}, 32'(triggered), 0);
    endtask

    // mode 0 random, 1 ramp level, 2 wrap after 20 samples, 3 mask zero, 4 edge on held level
    task automatic run_capture(input int mode, input int abort_at, input bit rst_in_dump);
        logic [7:0] m, v;
        bit ed;
        int t, n, wp0, blen, k;
        for (int i = 0; i < NS; i++) smp[i] = 8'($urandom);
        ed = 1'b0; m = 8'hFF; v = 8'($urandom);
        case (mode)
            1: begin v = 8'h55; for (int i = 0; i < NS; i++) smp[i] = 8'h50 + 8'(i); end
            2: begin v = 8'hAA; for (int i = 0; i < 20; i++) smp[i] = 8'h10 + 8'(i); smp[20] = 8'hAA; end
            3: m = 8'h00;
            4: begin
                ed = 1'b1; m = 8'h01; v = 8'h01;
                for (int i = 0; i < NS; i++) smp[i] = (i == 6) ? 8'h00 : 8'h01;
            end
            default: begin
                ed = 1'($urandom_range(0, 1));
                m  = 8'($urandom) & 8'($urandom) & 8'($urandom);
                if (ed && m == 8'h00) m = 8'h01;
            end
        endcase
        t = find_trig(m, v, ed);
        if (t < 0) begin
            smp[40] = ~v;
            smp[41] = v;
            t = find_trig(m, v, ed);
        end
        n   = (abort_at >= 0) ? abort_at : t + POST;
        wp0 = exp_wp;
        for (int i = 0; i < n; i++) begin
            wq.push_back('{addr: AW'(exp_wp), data: smp[i]});
            exp_wp = (exp_wp + 1) % DEPTH;
        end
        if (abort_at < 0) dq.push_back(AW'((wp0 + t - PRE) % DEPTH));

        trig_mask = m; trig_val = v; trig_edge = ed;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("armed_after_arm", 32'(armed), 1);
        chk("trig_after_arm", 32'(triggered), 0);
        for (int i = 0; i < n; i++) begin
            k = $urandom_range(0, 2);
            for (int g = 0; g < k; g++) tick();
            sample_en = 1'b1;
            sample_in = smp[i];
            tick();
            sample_en = 1'b0;
            chk("armed_window", 32'(armed), (i < t) ? 1 : 0);
            chk("triggered_window", 32'(triggered), (i < t) ? 0 : 1);
        end

        if (abort_at >= 0) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk("armed_after_abort", 32'(armed), 0);
            chk("trig_after_abort", 32'(triggered), 0);
            sample_en = 1'b1; sample_in = 8'($urandom);
            tick();
            sample_en = 1'b0;
            return;
        end

        k = 0;
        while (!start_dump && k < 10) begin tick(); k++; end
        chk("start_dump_seen", 32'(start_dump), 1);
        sample_en = 1'b1; sample_in = 8'($urandom);
        tick();
        dump_busy = 1'b1;
        if (rst_in_dump) begin
            tick();
            tick();
            #1 rst = 1'b0;
            #1 check_reset_outputs("rst_in_dump");
            exp_wp = 0;
            tick();
            sample_en = 1'b0; dump_busy = 1'b0;
            rst = 1'b1;
            return;
        end
        blen = $urandom_range(1, 4);
        for (int j = 0; j < blen; j++) begin
            arm = (j == 0); abort = (j == 1);
            sample_in = 8'($urandom);
            tick();
            chk("trig_in_dump", 32'(triggered), 1);
        end
        arm = 1'b0; abort = 1'b0; sample_en = 1'b0; dump_busy = 1'b0;
        k = 0;
        while (triggered && k < 10) begin tick(); k++; end
        chk("trig_cleared", 32'(triggered), 0);
        chk("armed_idle", 32'(armed), 0);
        sample_en = 1'b1; sample_in = 8'($urandom);
        tick();
        sample_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0; sample_en = 1'b0; sample_in = 8'h00; arm = 1'b0; abort = 1'b0;
        trig_mask = 8'h00; trig_val = 8'h00; trig_edge = 1'b0; dump_busy = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();

        run_capture(1, -1, 1'b0);
        run_capture(4, -1, 1'b0);
        run_capture(3, -1, 1'b0);
        run_capture(4, 9, 1'b0);
        run_capture(0, -1, 1'b0);
        run_capture(0, 2, 1'b0);

        arm = 1'b1; abort = 1'b1;
        tick();
        arm = 1'b0; abort = 1'b0;
        chk("arm_abort_idle", 32'(armed), 0);

        for (int r = 0; r < 20; r++) run_capture(0, -1, 1'b0);
        run_capture(0, -1, 1'b1);
        run_capture(2, -1, 1'b0);

        tick();
        tick();
        chk("write_queue_empty", 32'(wq.size()), 0);
        chk("dump_queue_empty", 32'(dq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Upstream acquisition stage of the logic probe.
- Writes 8-bit probe samples into the capture BRAM as a circular buffer and guarantees a full pre-trigger window.
- Detects a masked level or edge trigger, captures the post-trigger window, then hands the dump FSM a start address and sample count with a one-cycle start pulse.
- Waits for the dump to finish before it accepts a new arm.

Parameters:
- AW, 10, BRAM address width; the buffer holds 2^AW samples.
- PRE, 32, pre-trigger samples delivered before the trigger sample.
- POST, 96, samples delivered from the trigger sample onward, trigger sample included. Constraints: PRE+POST <= 2^AW, PRE+POST <= 65535, POST >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- sample_en  input  1  sample strobe from the rate divider, at most one per cycle.
- sample_in  input  8  probe channels, valid when sample_en=1.
- arm  input  1  start a capture; honoured only in IDLE.
- abort  input  1  cancel a capture; returns to IDLE from any state except WAIT_DUMP.
- trig_mask  input  8  channels that take part in the trigger compare.
- trig_val  input  8  required level on the masked channels.
- trig_edge  input  1  1 = trigger on the first match after a non-match; 0 = trigger on any match.
- we  output  1  BRAM write enable.
- waddr  output  AW  BRAM write address.
- wdata  output  8  BRAM write data.
- start_dump  output  1  one-cycle pulse to the dump FSM.
- start_addr  output  AW  address of the first sample to dump.
- count  output  16  number of samples to dump, always PRE+POST.
- dump_busy  input  1  busy flag from the dump FSM.
- armed  output  1  high in PREFILL and ARMED.
- triggered  output  1  high from the trigger sample until return to IDLE.

Behaviour:
- Reset values (async, rst=0): state=IDLE; we=0, waddr=0, wdata=0, start_dump=0, start_addr=0, count=PRE+POST, armed=0, triggered=0; write pointer wp=0; counters=0; prev_match=1.
- States: IDLE, PREFILL, ARMED, POST, HANDOFF, WAIT_DUMP.
- Write path:
  - In PREFILL, ARMED and POST, sample_en=1 registers we=1, waddr=wp, wdata=sample_in one cycle later.
  - wp increments modulo 2^AW on each write. There is no full condition: old data is overwritten.
  - In other states, we=0 and samples are dropped.
- match = ((sample_in ^ trig_val) & trig_mask) == 0. A trig_mask of 0 matches every sample.
- IDLE:
  - arm=1 clears the prefill/post counters and sets prev_match=1.
  - Goes to PREFILL, or straight to ARMED if PRE=0.
- PREFILL:
  - Counts written samples. When the count reaches PRE, goes to ARMED on the cycle after the PRE-th sample.
  - Trigger is not evaluated here.
  - prev_match is updated with each sample's match.
- ARMED:
  - Each written sample is evaluated. Trigger = match && (!trig_edge || !prev_match).
  - On trigger: trig_addr=wp of that sample, triggered=1, post counter=1. If POST=1, go to HANDOFF; otherwise go to POST.
  - prev_match updates on every sample.
- POST:
  - Each written sample increments the post counter. When it reaches POST, go to HANDOFF.
- HANDOFF:
  - One cycle. start_dump=1, start_addr=(trig_addr-PRE) mod 2^AW, count=PRE+POST.
  - Goes to WAIT_DUMP.
- WAIT_DUMP:
  - Waits for dump_busy to be seen high and then low. The seen-high flag covers the one-cycle latency before busy rises.
  - Then goes to IDLE and clears triggered.
  - arm and abort are ignored here.
- abort=1 in PREFILL, ARMED, POST or HANDOFF: go to IDLE next cycle. No start_dump issues, unless it already pulsed on this same cycle. armed and triggered clear. The BRAM contents are left as is.
- arm outside IDLE is ignored. arm and abort together in IDLE: abort wins and the state stays IDLE.
- sample_en on the same cycle as a state transition: the sample belongs to the state current on that cycle.
- Address arithmetic is AW-bit wrap, consistent with the dump FSM incrementing raddr with natural wrap.
- Reset mid-capture or mid-dump: immediate return to IDLE with reset values. In-flight BRAM writes stop at once.

Test Plan:
- PRE=4, POST=4, mask=0xFF, val=0x55, level mode. Feed ramp 0x50.. from wp=0 → trigger on 0x55 (index 5, trig_addr=5). Expect start_dump once, start_addr=1, count=8, and BRAM[1..8]=0x51..0x58.
- Edge mode, val=0x01, mask=0x01, input held 0x01 from arm → no trigger until a 0x00 sample then 0x01. Trigger at the 0x01 that follows the first 0x00.
- AW=4, PRE=4, POST=4, trigger after 20 samples (trig_addr=20 mod 16=4) → start_addr=0, waddr wraps 15→0 with no gaps.
- mask=0x00 → triggers on the first ARMED sample, which is sample index PRE. start_addr=0, count=PRE+POST.
- abort during POST → no start_dump, state IDLE, triggered=0. A new arm then runs a full capture.
- Reset asserted during WAIT_DUMP with dump_busy=1 → all outputs at reset values immediately. arm is honoured after deassertion.
